// File: rtl/flash_arbiter_if.sv
// Client-side handshake bundle for flash_arbiter: one level request, word address,
// one-cycle ack and held read word for each of the audio and graphics readers.
interface flash_arbiter_if #(
   parameter int ADDR_W = 22
);
   logic              aud_req;
   logic [ADDR_W-1:0] aud_addr;
   logic              aud_ack;
   logic [15:0]       aud_data;
   logic              gfx_req;
   logic [ADDR_W-1:0] gfx_addr;
   logic              gfx_ack;
   logic [15:0]       gfx_data;

   modport master (
      output aud_req, aud_addr, gfx_req, gfx_addr,
      input  aud_ack, aud_data, gfx_ack, gfx_data
   );

   modport slave (
      input  aud_req, aud_addr, gfx_req, gfx_addr,
      output aud_ack, aud_data, gfx_ack, gfx_data
   );
endinterface

// File: rtl/flash_arbiter.sv
// Shares one 8-bit flash between the audio and graphics word readers: each 16-bit
// read becomes two timed byte reads, with round-robin arbitration between clients.
module flash_arbiter #(
   parameter int WAIT_CYCLES = 5,
   parameter int ADDR_W      = 22
) (
   input  logic            CLOCK,
   input  logic            RESET_N,
   flash_arbiter_if.slave  bus,
   output logic [ADDR_W:0] FL_ADDR,
   input  logic [7:0]      FL_DQ,
   output logic            FL_CE_N,
   output logic            FL_OE_N,
   output logic            FL_WE_N,
   output logic            FL_RST_N,
   output logic            busy
);
   typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

   localparam logic [3:0] LAST_COUNT = 4'(WAIT_CYCLES - 1);

   state_t          state_reg;
   logic [3:0]      cnt_reg;
   logic            gfx_sel_reg;
   logic            last_gfx_reg;
   logic [7:0]      lo_byte_reg;
   logic [ADDR_W:0] addr_reg;
   logic            ce_n_reg;
   logic            rst_n_reg;
   logic            aud_ack_reg;
   logic            gfx_ack_reg;
   logic [15:0]     aud_data_reg;
   logic [15:0]     gfx_data_reg;
   logic            pick_gfx;

   // On a tie the client that was not served last wins.
   assign pick_gfx = bus.gfx_req && (!bus.aud_req || !last_gfx_reg);

   always_ff @(posedge CLOCK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_reg    <= IDLE;
         cnt_reg      <= '0;
         gfx_sel_reg  <= 1'b0;
         last_gfx_reg <= 1'b1;
         lo_byte_reg  <= '0;
         addr_reg     <= '0;
         ce_n_reg     <= 1'b1;
         rst_n_reg    <= 1'b0;
         aud_ack_reg  <= 1'b0;
         gfx_ack_reg  <= 1'b0;
         aud_data_reg <= '0;
         gfx_data_reg <= '0;
      end else begin
         rst_n_reg   <= 1'b1;
         aud_ack_reg <= 1'b0;
         gfx_ack_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (bus.aud_req || bus.gfx_req) begin
                  gfx_sel_reg <= pick_gfx;
                  addr_reg    <= {(pick_gfx ? bus.gfx_addr : bus.aud_addr), 1'b0};
                  ce_n_reg    <= 1'b0;
                  cnt_reg     <= '0;
                  state_reg   <= LO;
               end
            end
            LO: begin
               if (cnt_reg == LAST_COUNT) begin
                  lo_byte_reg <= FL_DQ;
                  addr_reg[0] <= 1'b1;
                  cnt_reg     <= '0;
                  state_reg   <= HI;
               end else begin
                  cnt_reg <= cnt_reg + 4'd1;
               end
            end
            HI: begin
               // Ack and data are registered here so both are visible during DONE.
               if (cnt_reg == LAST_COUNT) begin
                  ce_n_reg     <= 1'b1;
                  last_gfx_reg <= gfx_sel_reg;
                  if (gfx_sel_reg) begin
                     gfx_data_reg <= {FL_DQ, lo_byte_reg};
                     gfx_ack_reg  <= 1'b1;
                  end else begin
                     aud_data_reg <= {FL_DQ, lo_byte_reg};
                     aud_ack_reg  <= 1'b1;
                  end
                  cnt_reg   <= '0;
                  state_reg <= DONE;
               end else begin
                  cnt_reg <= cnt_reg + 4'd1;
               end
            end
            DONE: begin
               state_reg <= IDLE;
            end
            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

   assign FL_ADDR      = addr_reg;
   assign FL_CE_N      = ce_n_reg;
   assign FL_OE_N      = ce_n_reg;
   assign FL_WE_N      = 1'b1;
   assign FL_RST_N     = rst_n_reg;
   assign busy         = (state_reg != IDLE);
   assign bus.aud_ack  = aud_ack_reg;
   assign bus.gfx_ack  = gfx_ack_reg;
   assign bus.aud_data = aud_data_reg;
   assign bus.gfx_data = gfx_data_reg;
endmodule

// File: tb/tb_flash_arbiter.sv
// Self-checking bench for flash_arbiter: a W=1 instance driven from a vector table,
// and a W=5 instance driven by directed sequences plus random traffic against a model.
module tb_flash_arbiter;
   localparam int AW = 22;
   localparam int W5 = 5;

   logic CLOCK = 1'b0;
   always #10 CLOCK = ~CLOCK;

   logic          rst5_n, rst1_n;
   logic [AW:0]   fa5, fa1;
   logic [7:0]    dq5, dq1;
   logic          ce5, oe5, we5, fr5, busy5;
   logic          ce1, oe1, we1, fr1, busy1;

   flash_arbiter_if #(.ADDR_W(AW)) b5 ();
   flash_arbiter_if #(.ADDR_W(AW)) b1 ();

   // Flash model: each byte reads back as the low 8 bits of its own address.
   assign dq5 = fa5[7:0];
   assign dq1 = fa1[7:0];

   flash_arbiter #(.WAIT_CYCLES(W5), .ADDR_W(AW)) dut5 (
      .CLOCK(CLOCK), .RESET_N(rst5_n), .bus(b5), .FL_ADDR(fa5), .FL_DQ(dq5),
      .FL_CE_N(ce5), .FL_OE_N(oe5), .FL_WE_N(we5), .FL_RST_N(fr5), .busy(busy5)
   );

   flash_arbiter #(.WAIT_CYCLES(1), .ADDR_W(AW)) dut1 (
      .CLOCK(CLOCK), .RESET_N(rst1_n), .bus(b1), .FL_ADDR(fa1), .FL_DQ(dq1),
      .FL_CE_N(ce1), .FL_OE_N(oe1), .FL_WE_N(we1), .FL_RST_N(fr1), .busy(busy1)
   );

   int total = 0;
   int bad   = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLOCK);
      @(negedge CLOCK);
   endtask

   // Word the flash model returns for a word address: even byte low, odd byte high.
   function automatic logic [15:0] word_of(input logic [AW-1:0] a);
      logic [7:0] e;
      e = {a[6:0], 1'b0};
      return {e | 8'h01, e};
   endfunction

   function automatic logic [AW-1:0] rand_addr();
      if ($urandom_range(3) == 0) return '1;
      return AW'($urandom);
   endfunction

   typedef struct {
      logic          ar;
      logic [AW-1:0] aa;
      logic          gr;
      logic [AW-1:0] ga;
      logic          exp_gfx;
      logic [15:0]   exp_data;
   } vec_t;

   vec_t          tbl[6];
   int            n, acks, prev;
   logic [AW-1:0] waddr;
   logic [15:0]   ead, egd;
   int            m_left, idx;
   logic          m_gfx, m_last_gfx;
   logic [AW-1:0] m_addr;
   logic          e_ack;

   initial begin
      tbl[0] = '{1'b1, 22'h3FFFFF, 1'b0, 22'h000000, 1'b0, 16'hFFFE};
      tbl[1] = '{1'b1, 22'h000005, 1'b1, 22'h000009, 1'b1, 16'h1312};
      tbl[2] = '{1'b1, 22'h000005, 1'b1, 22'h000009, 1'b0, 16'h0B0A};
      tbl[3] = '{1'b0, 22'h000000, 1'b1, 22'h000080, 1'b1, 16'h0100};
      tbl[4] = '{1'b1, 22'h000040, 1'b1, 22'h000002, 1'b0, 16'h8180};
      tbl[5] = '{1'b1, 22'h000001, 1'b1, 22'h000002, 1'b1, 16'h0504};

      rst5_n = 1'b0; rst1_n = 1'b0;
      b5.aud_req = 1'b0; b5.gfx_req = 1'b0; b5.aud_addr = '0; b5.gfx_addr = '0;
      b1.aud_req = 1'b0; b1.gfx_req = 1'b0; b1.aud_addr = '0; b1.gfx_addr = '0;
      @(negedge CLOCK);
      tick();

      chk("rst_addr", 32'(fa5), 32'h0);
      chk("rst_ce", 32'(ce5), 32'h1);
      chk("rst_oe", 32'(oe5), 32'h1);
      chk("rst_we", 32'(we5), 32'h1);
      chk("rst_flrst", 32'(fr5), 32'h0);
      chk("rst_busy", 32'(busy5), 32'h0);
      chk("rst_acks", 32'({b5.aud_ack, b5.gfx_ack}), 32'h0);
      chk("rst_data", 32'({b5.aud_data, b5.gfx_data}), 32'h0);

      rst5_n = 1'b1; rst1_n = 1'b1;
      tick();
      chk("flrst_rel", 32'(fr5), 32'h1);

      // ---- W=1 vector table: arbitration order, wrap, late address changes ----
      ead = '0; egd = '0;
      for (int i = 0; i < 6; i++) begin
         b1.aud_req = tbl[i].ar; b1.aud_addr = tbl[i].aa;
         b1.gfx_req = tbl[i].gr; b1.gfx_addr = tbl[i].ga;
         waddr = tbl[i].exp_gfx ? tbl[i].ga : tbl[i].aa;
         n = 0;
         while (n < 20 && !(b1.aud_ack || b1.gfx_ack)) begin
            tick();
            n++;
            if (n == 1) begin
               chk("t_addr_lo", 32'(fa1), 32'({waddr, 1'b0}));
               b1.aud_addr = rand_addr();
               b1.gfx_addr = rand_addr();
            end
            if (n == 2) chk("t_addr_hi", 32'(fa1), 32'({waddr, 1'b1}));
            chk("t_we", 32'(we1), 32'h1);
         end
         chk("t_latency", n, 3);
         chk("t_who", 32'({b1.aud_ack, b1.gfx_ack}), tbl[i].exp_gfx ? 32'h1 : 32'h2);
         if (tbl[i].exp_gfx) egd = tbl[i].exp_data;
         else ead = tbl[i].exp_data;
         chk("t_aud_data", 32'(b1.aud_data), 32'(ead));
         chk("t_gfx_data", 32'(b1.gfx_data), 32'(egd));
         b1.aud_req = 1'b0; b1.gfx_req = 1'b0;
         tick();
         chk("t_idle", 32'(busy1), 32'h0);
      end

      // ---- W=5 single audio read ----
      b5.aud_req = 1'b1; b5.aud_addr = 22'h000010;
      n = 0;
      while (n < 30 && !b5.aud_ack) begin
         tick();
         n++;
         if (n <= 5) chk("s_addr_lo", 32'(fa5), 32'h20);
         else if (n <= 10) chk("s_addr_hi", 32'(fa5), 32'h21);
         if (n <= 10) chk("s_ce", 32'({ce5, oe5}), 32'h0);
      end
      chk("s_latency", n, 11);
      chk("s_aud_data", 32'(b5.aud_data), 32'h2120);
      chk("s_gfx_data", 32'(b5.gfx_data), 32'h0);
      chk("s_ce_done", 32'(ce5), 32'h1);
      b5.aud_req = 1'b0;
      tick();
      tick();
      chk("s_ack_pulse", 32'(b5.aud_ack), 32'h0);

      // ---- W=5 simultaneous first requests, then sustained contention ----
      rst5_n = 1'b0;
      tick();
      rst5_n = 1'b1;
      tick();
      b5.aud_req = 1'b1; b5.aud_addr = 22'h5;
      b5.gfx_req = 1'b1; b5.gfx_addr = 22'h9;
      n = 0; acks = 0; prev = 0;
      while (acks < 6 && n < 150) begin
         tick();
         n++;
         if (b5.aud_ack || b5.gfx_ack) begin
            chk("c_who", 32'({b5.aud_ack, b5.gfx_ack}), (acks % 2 == 1) ? 32'h1 : 32'h2);
            chk("c_gap", n - prev, (acks == 0) ? 11 : 12);
            if (acks % 2 == 1) chk("c_gfx_data", 32'(b5.gfx_data), 32'h1312);
            else chk("c_aud_data", 32'(b5.aud_data), 32'h0B0A);
            prev = n;
            acks++;
         end
      end
      chk("c_count", acks, 6);
      b5.aud_req = 1'b0; b5.gfx_req = 1'b0;
      tick();
      tick();

      // ---- W=5 reset in the third HI cycle ----
      b5.aud_req = 1'b1; b5.aud_addr = 22'h33;
      for (int i = 0; i < 8; i++) tick();
      chk("r_in_hi", 32'(fa5), 32'h67);
      #2 rst5_n = 1'b0;
      #1;
      chk("r_ce", 32'({ce5, oe5}), 32'h3);
      chk("r_flrst", 32'(fr5), 32'h0);
      chk("r_busy", 32'(busy5), 32'h0);
      chk("r_data", 32'({b5.aud_data, b5.gfx_data}), 32'h0);
      chk("r_ack", 32'({b5.aud_ack, b5.gfx_ack}), 32'h0);
      b5.aud_req = 1'b0;
      @(negedge CLOCK);
      tick();
      rst5_n = 1'b1;
      tick();
      b5.gfx_req = 1'b1; b5.gfx_addr = 22'h77;
      n = 0;
      while (n < 30 && !b5.gfx_ack) begin
         tick();
         n++;
         chk("r_no_aud_ack", 32'(b5.aud_ack), 32'h0);
      end
      chk("r_latency", n, 11);
      chk("r_gfx_data", 32'(b5.gfx_data), 32'(word_of(22'h77)));
      chk("r_aud_data", 32'(b5.aud_data), 32'h0);
      b5.gfx_req = 1'b0;
      tick();

      // ---- W=5 random traffic against a transaction-timeline model ----
      rst5_n = 1'b0;
      tick();
      rst5_n = 1'b1;
      tick();
      m_left = 0; m_last_gfx = 1'b1; m_gfx = 1'b0; m_addr = '0;
      ead = '0; egd = '0;
      for (int c = 0; c < 1500; c++) begin
         @(posedge CLOCK);
         if (m_left > 0) begin
            m_left--;
         end else if (b5.aud_req || b5.gfx_req) begin
            m_gfx  = b5.gfx_req && (!b5.aud_req || !m_last_gfx);
            m_addr = m_gfx ? b5.gfx_addr : b5.aud_addr;
            m_left = 2 * W5 + 1;
         end
         @(negedge CLOCK);
         e_ack = (m_left == 1);
         if (e_ack) begin
            m_last_gfx = m_gfx;
            if (m_gfx) egd = word_of(m_addr);
            else ead = word_of(m_addr);
         end
         chk("m_busy", 32'(busy5), 32'(m_left > 0));
         chk("m_acks", 32'({b5.aud_ack, b5.gfx_ack}), 32'({e_ack && !m_gfx, e_ack && m_gfx}));
         chk("m_aud_data", 32'(b5.aud_data), 32'(ead));
         chk("m_gfx_data", 32'(b5.gfx_data), 32'(egd));
         chk("m_ce", 32'({ce5, oe5}), (m_left > 1) ? 32'h0 : 32'h3);
         if (m_left > 1) begin
            idx = 2 * W5 + 1 - m_left;
            chk("m_addr", 32'(fa5), 32'({m_addr, idx >= W5}));
         end
         if (b5.aud_ack) begin
            if ($urandom_range(1) == 0) b5.aud_req = 1'b0;
            else b5.aud_addr = rand_addr();
         end else if (!b5.aud_req && $urandom_range(2) == 0) begin
            b5.aud_req = 1'b1; b5.aud_addr = rand_addr();
         end
         if (b5.gfx_ack) begin
            if ($urandom_range(1) == 0) b5.gfx_req = 1'b0;
            else b5.gfx_addr = rand_addr();
         end else if (!b5.gfx_req && $urandom_range(2) == 0) begin
            b5.gfx_req = 1'b1; b5.gfx_addr = rand_addr();
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
